// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter that time-shares one external combinational ALU.
// Each port holds at most one operation: accept -> issue stage -> response register.
module alu_share_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic [2:0]  req0_control,
  input  logic [2:0]  req1_control,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp0_out,
  output logic [31:0] rsp1_out,
  output logic [2:0]  rsp0_flags,
  output logic [2:0]  rsp1_flags,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_out,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  input  logic        alu_negative,
  output logic        alu_busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUED = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // Handshake: a request transfers at a rising edge where req_valid[i] and
  // req_ready[i] are both high; a response transfers where rsp_valid[i] and
  // rsp_ready[i] are both high. Neither ready depends on the same-port valid.

  logic [1:0]  state0;
  logic [1:0]  state1;
  logic        last;
  logic [1:0]  idle;
  logic [1:0]  eligible;
  logic [1:0]  grant;
  logic [1:0]  accept;
  logic [1:0]  consume;

  logic        stage_valid;
  logic        stage_id;
  logic [31:0] stage_A;
  logic [31:0] stage_B;
  logic [2:0]  stage_control;

  function automatic logic [1:0] port_next(input logic [1:0] st,
                                           input logic acc,
                                           input logic cons);
    logic [1:0] nxt;
    nxt = IDLE;
    case (st)
      IDLE:    nxt = acc ? ISSUED : IDLE;
      ISSUED:  nxt = DONE;
      DONE:    nxt = cons ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

  // With no contender the grant rests on the port that did not win last,
  // so req_ready is only high without valid when the other port is not asking.
  always_comb begin
    idle     = {state1 == IDLE, state0 == IDLE};
    eligible = req_valid & idle;
    grant    = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      default: grant = last ? 2'b01 : 2'b10;
    endcase
    req_ready = idle & grant;
    accept    = req_valid & req_ready;
    rsp_valid = {state1 == DONE, state0 == DONE};
    consume   = rsp_valid & rsp_ready;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state0 <= IDLE;
      state1 <= IDLE;
      last   <= 1'b1;
    end else begin
      state0 <= port_next(state0, accept[0], consume[0]);
      state1 <= port_next(state1, accept[1], consume[1]);
      if (|accept) last <= accept[1];
    end
  end

  // The stage is zeroed whenever nothing is accepted, so the ALU inputs read 0 when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_valid   <= 1'b0;
      stage_id      <= 1'b0;
      stage_A       <= 32'd0;
      stage_B       <= 32'd0;
      stage_control <= 3'd0;
    end else if (|accept) begin
      stage_valid   <= 1'b1;
      stage_id      <= accept[1];
      stage_A       <= accept[1] ? req1_A : req0_A;
      stage_B       <= accept[1] ? req1_B : req0_B;
      stage_control <= accept[1] ? req1_control : req0_control;
    end else begin
      stage_valid   <= 1'b0;
      stage_id      <= 1'b0;
      stage_A       <= 32'd0;
      stage_B       <= 32'd0;
      stage_control <= 3'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp0_out   <= 32'd0;
      rsp1_out   <= 32'd0;
      rsp0_flags <= 3'd0;
      rsp1_flags <= 3'd0;
    end else if (stage_valid) begin
      if (stage_id) begin
        rsp1_out   <= alu_out;
        rsp1_flags <= {alu_overflow, alu_zero, alu_negative};
      end else begin
        rsp0_out   <= alu_out;
        rsp0_flags <= {alu_overflow, alu_zero, alu_negative};
      end
    end
  end

  assign alu_A       = stage_A;
  assign alu_B       = stage_B;
  assign alu_control = stage_control;
  assign alu_busy    = stage_valid;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU, per-port op queues, expected-response
// queues popped by a monitor whenever a response is consumed.
module tb_alu_share_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_A, req0_B, req1_A, req1_B;
  logic [2:0]  req0_control, req1_control;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp0_out, rsp1_out;
  logic [2:0]  rsp0_flags, rsp1_flags;
  logic [31:0] alu_A, alu_B;
  logic [2:0]  alu_control;
  logic [31:0] alu_out;
  logic        alu_overflow, alu_zero, alu_negative;
  logic        alu_busy;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    logic [31:0] o;
    logic [2:0]  f;
  } op_t;

  op_t         op_q0[$];
  op_t         op_q1[$];
  logic [34:0] exp_q0[$];
  logic [34:0] exp_q1[$];
  int          acc_log[$];
  int          acc_cyc1[$];
  int          cyc;
  int          errors;
  int          checks;

  alu_share_arbiter dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req1_A(req1_A), .req1_B(req1_B),
    .req0_control(req0_control), .req1_control(req1_control),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp0_out(rsp0_out), .rsp1_out(rsp1_out),
    .rsp0_flags(rsp0_flags), .rsp1_flags(rsp1_flags),
    .alu_A(alu_A), .alu_B(alu_B), .alu_control(alu_control),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_busy(alu_busy)
  );

  // ALU codes: 0 AND, 1 OR, 2 ADD, 3 XOR, 6 SUB, 7 SLT
  always_comb begin
    alu_out      = 32'd0;
    alu_overflow = 1'b0;
    case (alu_control)
      3'd0: alu_out = alu_A & alu_B;
      3'd1: alu_out = alu_A | alu_B;
      3'd2: alu_out = alu_A + alu_B;
      3'd3: alu_out = alu_A ^ alu_B;
      3'd6: alu_out = alu_A - alu_B;
      3'd7: alu_out = {31'd0, $signed(alu_A) < $signed(alu_B)};
      default: alu_out = 32'd0;
    endcase
    if (alu_control == 3'd2)
      alu_overflow = (alu_A[31] == alu_B[31]) && (alu_out[31] != alu_A[31]);
    if (alu_control == 3'd6)
      alu_overflow = (alu_A[31] != alu_B[31]) && (alu_out[31] != alu_A[31]);
    alu_zero     = (alu_out == 32'd0);
    alu_negative = alu_out[31];
  end

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_op(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input logic [31:0] o, input logic [2:0] f);
    op_t op;
    op.a = a; op.b = b; op.c = c; op.o = o; op.f = f;
    if (p == 0) op_q0.push_back(op);
    else        op_q1.push_back(op);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    op_q0.delete(); op_q1.delete();
    exp_q0.delete(); exp_q1.delete();
    @(negedge clock);
    check("rst_low_rsp_valid", rsp_valid, 2'b00);
    check("rst_low_busy", alu_busy, 1'b0);
    check("rst_low_alu_A", alu_A, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_req_ready", req_ready, 2'b01);
    check("rst_busy", alu_busy, 1'b0);
    check("rst_alu_ops", {alu_A, alu_B}, 64'd0);
    check("rst_alu_control", alu_control, 3'd0);
    check("rst_rsp_out", {rsp0_out, rsp1_out}, 64'd0);
    check("rst_rsp_flags", {rsp0_flags, rsp1_flags}, 6'd0);
  endtask

  task automatic wait_push(input int p, input int budget);
    int n;
    n = 0;
    while (n < budget && ((p == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
      @(posedge clock); #2;
      n++;
    end
    check("accept_timeout", n < budget, 1'b1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !(op_q0.size() == 0 && op_q1.size() == 0 &&
                           exp_q0.size() == 0 && exp_q1.size() == 0 &&
                           rsp_valid == 2'b00 && !alu_busy)) begin
      @(posedge clock); #2;
      n++;
    end
    check(name, n < budget, 1'b1);
  endtask

  task automatic check_order(input string name, input int n, input logic [31:0] exp);
    logic [31:0] ord;
    ord = 32'd0;
    foreach (acc_log[i]) ord = {ord[27:0], 4'(acc_log[i])};
    check({name, "_count"}, acc_log.size(), n);
    check(name, ord, exp);
  endtask

  // ---------------- driver ----------------
  initial begin : driver
    logic [1:0] acc;
    req_valid = 2'b00;
    req0_A = 0; req0_B = 0; req1_A = 0; req1_B = 0;
    req0_control = 0; req1_control = 0;
    cyc = 0;
    forever begin
      @(negedge clock);
      acc = reset ? (req_valid & req_ready) : 2'b00;
      @(posedge clock); #1;
      cyc++;
      if (reset && acc[0] && op_q0.size() > 0) begin
        exp_q0.push_back({op_q0[0].f, op_q0[0].o});
        op_q0.delete(0);
        acc_log.push_back(0);
      end
      if (reset && acc[1] && op_q1.size() > 0) begin
        exp_q1.push_back({op_q1[0].f, op_q1[0].o});
        op_q1.delete(0);
        acc_log.push_back(1);
        acc_cyc1.push_back(cyc);
      end
      if (reset && op_q0.size() > 0) begin
        req_valid[0] = 1'b1;
        req0_A = op_q0[0].a; req0_B = op_q0[0].b; req0_control = op_q0[0].c;
      end else begin
        req_valid[0] = 1'b0;
        req0_A = $urandom; req0_B = $urandom; req0_control = 3'($urandom_range(0, 7));
      end
      if (reset && op_q1.size() > 0) begin
        req_valid[1] = 1'b1;
        req1_A = op_q1[0].a; req1_B = op_q1[0].b; req1_control = op_q1[0].c;
      end else begin
        req_valid[1] = 1'b0;
        req1_A = $urandom; req1_B = $urandom; req1_control = 3'($urandom_range(0, 7));
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [34:0] e;
    forever begin
      @(negedge clock);
      if (reset && rsp_valid[0] && rsp_ready[0]) begin
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp0_unexpected: got %0h expected none", rsp0_out);
        end else begin
          e = exp_q0.pop_front();
          check("rsp0_out", rsp0_out, e[31:0]);
          check("rsp0_flags", rsp0_flags, e[34:32]);
        end
      end
      if (reset && rsp_valid[1] && rsp_ready[1]) begin
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp1_unexpected: got %0h expected none", rsp1_out);
        end else begin
          e = exp_q1.pop_front();
          check("rsp1_out", rsp1_out, e[31:0]);
          check("rsp1_flags", rsp1_flags, e[34:32]);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;
    errors = 0;
    checks = 0;
    reset = 1'b0;
    rsp_ready = 2'b00;
    do_reset();

    // single op, latency and hold
    add_op(0, 32'd5, 32'd3, 3'd2, 32'd8, 3'b000);
    wait_push(0, 20);
    @(negedge clock);
    check("t1_busy", alu_busy, 1'b1);
    check("t1_alu_ops", {alu_A, alu_B}, {32'd5, 32'd3});
    check("t1_alu_control", alu_control, 3'd2);
    check("t1_no_early_rsp", rsp_valid, 2'b00);
    @(negedge clock);
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_rsp0_out", rsp0_out, 32'd8);
    check("t1_rsp0_flags", rsp0_flags, 3'b000);
    check("t1_busy_clear", alu_busy, 1'b0);
    repeat (3) begin
      @(negedge clock);
      check("t1_hold_valid", rsp_valid[0], 1'b1);
      check("t1_hold_ready", req_ready[0], 1'b0);
    end
    @(posedge clock); #2;
    add_op(0, 32'h0F0F0F0F, 32'h00FF00FF, 3'd3, 32'h0FF00FF0, 3'b000);
    @(posedge clock); #2;
    rsp_ready = 2'b01;
    @(negedge clock);
    check("t1_consume_cycle_ready", req_ready[0], 1'b0);
    check("t1_consume_cycle_valid", rsp_valid[0], 1'b1);
    @(negedge clock);
    check("t1_after_consume_ready", req_ready[0], 1'b1);
    check("t1_after_consume_valid", rsp_valid[0], 1'b0);
    wait_idle("t1_drain", 40);

    // tie fairness from reset
    do_reset();
    rsp_ready = 2'b11;
    acc_log.delete();
    add_op(0, 32'd5, 32'd3, 3'd2, 32'd8, 3'b000);
    add_op(1, 32'd3, 32'd5, 3'd6, 32'hFFFFFFFE, 3'b001);
    add_op(0, 32'hF0F0F0F0, 32'hFF00FF00, 3'd0, 32'hF000F000, 3'b001);
    add_op(1, 32'd1, 32'd2, 3'd1, 32'd3, 3'b000);
    wait_idle("t2_drain", 60);
    check_order("t2_order", 4, 32'h0101);

    // flags; port 1 won last, so port 0 takes the tie
    acc_log.delete();
    add_op(1, 32'h7FFFFFFF, 32'd1, 3'd2, 32'h80000000, 3'b101);
    add_op(0, 32'hA5A5A5A5, 32'hA5A5A5A5, 3'd3, 32'd0, 3'b010);
    wait_idle("t3_drain", 40);
    check_order("t3_order", 2, 32'h01);

    // port 0 wins alone, then the tie goes to port 1
    add_op(0, 32'd1, 32'd2, 3'd1, 32'd3, 3'b000);
    wait_idle("t4_pre_drain", 40);
    acc_log.delete();
    add_op(0, 32'hFFFF0000, 32'h0000FFFF, 3'd0, 32'd0, 3'b010);
    add_op(1, 32'd2, 32'd2, 3'd2, 32'd4, 3'b000);
    wait_idle("t4_drain", 40);
    check_order("t4_order", 2, 32'h10);

    // backpressure on port 0, port 1 keeps streaming
    rsp_ready = 2'b10;
    acc_cyc1.delete();
    add_op(0, 32'd10, 32'd10, 3'd6, 32'd0, 3'b010);
    add_op(0, 32'h80000000, 32'd1, 3'd1, 32'h80000001, 3'b001);
    add_op(1, 32'd1, 32'd1, 3'd2, 32'd2, 3'b000);
    add_op(1, 32'hFFFFFFFF, 32'd1, 3'd2, 32'd0, 3'b010);
    add_op(1, 32'h80000000, 32'd1, 3'd6, 32'h7FFFFFFF, 3'b100);
    add_op(1, 32'hFFFFFFFF, 32'h12345678, 3'd0, 32'h12345678, 3'b000);
    n = 0;
    while (n < 20 && !rsp_valid[0]) begin
      @(negedge clock);
      n++;
    end
    check("t5_rsp0_timeout", n < 20, 1'b1);
    repeat (10) begin
      @(negedge clock);
      check("t5_blocked_ready", req_ready[0], 1'b0);
      check("t5_held_valid", rsp_valid[0], 1'b1);
      check("t5_held_out", {rsp0_flags, rsp0_out}, {3'b010, 32'd0});
    end
    @(posedge clock); #2;
    rsp_ready = 2'b11;
    wait_idle("t5_drain", 60);
    check("t5_port1_count", acc_cyc1.size(), 4);
    for (int i = 1; i < acc_cyc1.size(); i++)
      check("t5_port1_spacing", acc_cyc1[i] - acc_cyc1[i-1], 3);

    // reset the cycle after an accept
    rsp_ready = 2'b00;
    add_op(0, 32'd7, 32'd7, 3'd2, 32'd14, 3'b000);
    wait_push(0, 20);
    do_reset();
    rsp_ready = 2'b11;
    repeat (4) begin
      @(negedge clock);
      check("t6_no_rsp", rsp_valid, 2'b00);
      check("t6_no_busy", alu_busy, 1'b0);
    end
    acc_log.delete();
    add_op(0, 32'd100, 32'd23, 3'd2, 32'd123, 3'b000);
    add_op(1, 32'd0, 32'd1, 3'd6, 32'hFFFFFFFF, 3'b001);
    wait_idle("t6_drain", 40);
    check_order("t6_order", 2, 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-port arbiter and sequencer that time-shares one combinational 32-bit ALU (`alu32`: `out`, `overflow`, `zero`, `negative`; 3-bit `control`) between two requesters. Each requester issues operations over a valid/ready handshake and receives a registered result plus flags. One operation is accepted per cycle, with round-robin fairness and at most one outstanding operation per port. The block sits between the ALU instance and the two client datapaths.

## Interface
- No parameters; data width fixed at 32, control width fixed at 3.
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  asynchronous, active-low reset; all state cleared while low.
- `req_valid[1:0]`  in  2  bit i: port i presents an operation.
- `req_ready[1:0]`  out  2  bit i: port i's operation is accepted at this edge when its valid is also high.
- `req0_A`, `req0_B`, `req1_A`, `req1_B`  in  32 each  operands per port.
- `req0_control`, `req1_control`  in  3 each  ALU control code per port, passed to the ALU unchanged.
- `rsp_valid[1:0]`  out  2  bit i: port i result held and valid.
- `rsp_ready[1:0]`  in  2  bit i: port i consumes its result at this edge when its valid is also high.
- `rsp0_out`, `rsp1_out`  out  32 each  registered ALU result.
- `rsp0_flags`, `rsp1_flags`  out  3 each  registered {overflow, zero, negative}.
- `alu_A`, `alu_B`  out  32 each  to ALU operand inputs.
- `alu_control`  out  3  to ALU control.
- `alu_out`  in  32  from ALU.
- `alu_overflow`, `alu_zero`, `alu_negative`  in  1 each  from ALU.
- `alu_busy`  out  1  high while the issue stage holds an operation.

## Operation
- Each port has a state register with three states:
  - IDLE: no outstanding operation.
  - ISSUED: operands are in the issue stage.
  - DONE: result held in that port's response register.
- Port transitions:
  - IDLE → ISSUED on accept.
  - ISSUED → DONE unconditionally on the next edge.
  - DONE → IDLE when `rsp_valid[i] && rsp_ready[i]`.
- Eligible_i = `req_valid[i]` && port i in IDLE.
- Grant logic (combinational):
  - If only one port is eligible, grant that port.
  - If both are eligible, grant the port that did not win the last accept.
  - `req_ready[i]` = port i in IDLE && grant_i. `req_ready[i]` may be high while `req_valid[i]` is low only if the other port is not eligible.
- Round-robin pointer `last` resets to 1, so port 0 wins the first tie. It updates only on an accept.
- Issue stage is a single register set: `stage_valid`, `stage_id`, `stage_A`, `stage_B`, `stage_control`. It loads on every accept and clears otherwise. No accept means `stage_valid` = 0 next cycle.
- `alu_A`, `alu_B`, `alu_control` are driven directly from the stage registers. They show 0 when `stage_valid` = 0.
- When `stage_valid` = 1, the next edge captures `alu_out` and the flags into the response register selected by `stage_id`.
- Response registers hold their value until overwritten by the next completion for that port. They are not cleared on consume.
- `alu_busy` = `stage_valid`.
- The ALU is purely combinational; no arithmetic is done in this block. Widths are passed through unchanged.

## Timing
- Reset values: both ports IDLE, `stage_valid` = 0, `stage_id` = 0, `last` = 1.
  - All `rsp*_out` and `rsp*_flags` = 0; `rsp_valid` = 0; `alu_A`/`alu_B`/`alu_control` = 0; `alu_busy` = 0.
  - `req_ready` follows the grant equation immediately after reset.
- Latency: accept at edge T → `stage_valid` and `alu_busy` high in cycle T..T+1 → `rsp_valid[i]` high after edge T+1. Two cycles accept-to-response.
- Throughput: one accept per cycle aggregate. Per port, at most one accept per three cycles, since consume must occur before the next accept.
- Consume and re-request in the same cycle: `req_ready[i]` is 0 because the port is still DONE. The earliest new accept is the edge after consume.
- A response held indefinitely (`rsp_ready` low) blocks only that port; the other port continues at full rate.
- Reset asserted mid-operation: in-flight stage and pending responses are discarded. No response is emitted after reset deassertion.
- Operands and control are sampled only at the accept edge. Changes afterwards do not affect the result.

## Test plan
- Single op: after reset, port 0 sends A=5, B=3, control=ADD(2) → `req_ready[0]`=1, `rsp_valid[0]` high two edges later, `rsp0_out`=8, flags=000; held until `rsp_ready[0]`.
- Tie fairness: both ports valid every cycle with `rsp_ready`=11 → accepts go port 0, 1, 0, 1…; port 1 op SUB 3−5 gives `rsp1_out`=0xFFFFFFFE, flags=001.
- Flags: port 1 ADD 0x7FFFFFFF+1 → `rsp1_out`=0x80000000, flags=101; port 0 XOR 0xA5A5A5A5^0xA5A5A5A5 → 0, flags=010.
- Backpressure: port 0 `rsp_ready`=0 for 10 cycles with `req_valid[0]` held → `req_ready[0]`=0 throughout, `rsp0_out` stable, port 1 completes an op every 3 cycles.
- Reset mid-flight: drop `reset` the cycle after accept → all outputs at reset values, no `rsp_valid` after release, first tie then goes to port 0.
